// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, column reset pattern,
// position field layout and the row/column index encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET   = 4'b0001;
  localparam int         POS_W       = 4;
  localparam int         IDX_W       = 2;
  localparam int         POS_COL_LSB = 2;
  localparam int         POS_ROW_LSB = 0;

  // Index of the lowest set bit; bit 0 wins when several are set.
  function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [3:0] v);
    lowest_set_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scan_fsm_scan_tick_gen.sv
// Free-running modulo-DIV counter; tick is high during the last cycle of each dwell.
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_fsm.sv
// Keypad column scanner: confirms a press over two dwells and emits a one-cycle opr strobe.
// Optional held-key auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       fila,
  output logic [3:0]       col,
  output logic [POS_W-1:0] posicion,
  output logic             opr,
  output logic             key_held
);

  logic             w_tick;
  logic [IDX_W-1:0] w_row_idx;
  logic [IDX_W-1:0] w_col_idx;
  logic [3:0]       w_col_rot;
  logic             w_fila_any;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_col;
  logic [3:0]       w_col_next;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_next;
  logic             r_opr;
  logic             w_opr_next;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_row_idx  = lowest_set_idx(fila);
  assign w_col_idx  = lowest_set_idx(r_col);
  assign w_col_rot  = {r_col[2:0], r_col[3]};
  assign w_fila_any = |fila;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_next;
`endif

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_pos_next   = r_pos;
    w_opr_next   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_next   = '0;
`endif
    case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (w_fila_any) begin
            w_pos_next[POS_COL_LSB +: IDX_W] = w_col_idx;
            w_pos_next[POS_ROW_LSB +: IDX_W] = w_row_idx;
            w_state_next = ST_CONFIRM;
          end else begin
            w_col_next = w_col_rot;
          end
        end
      end
      ST_CONFIRM: begin
        if (w_tick) begin
          if (w_fila_any && (w_row_idx == r_pos[POS_ROW_LSB +: IDX_W])) begin
            w_state_next = ST_HOLD;
            w_opr_next   = 1'b1;
          end else begin
            w_col_next   = w_col_rot;
            w_state_next = ST_SCAN;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick && !w_fila_any) begin
          w_col_next   = w_col_rot;
          w_state_next = ST_SCAN;
        end
`ifdef KEYPAD_REPEAT_EN
        // Counter reads cycles since HOLD entry, so the repeat lands REPEAT_CYCLES after the entry strobe.
        else if (r_rep == REP_W'(REPEAT_CYCLES - 1)) begin
          w_opr_next = 1'b1;
          w_rep_next = '0;
        end else begin
          w_rep_next = r_rep + 1'b1;
        end
`endif
      end
      default: begin
        w_state_next = ST_SCAN;
        w_col_next   = COL_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_SCAN;
      r_col   <= COL_RESET;
      r_pos   <= '0;
      r_opr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_pos   <= w_pos_next;
      r_opr   <= w_opr_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_rep_next;
    end
  end
`endif

  assign col      = r_col;
  assign posicion = r_pos;
  assign opr      = r_opr;
  assign key_held = (r_state == ST_HOLD);

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Directed bench for keypad_scan_fsm (SCAN_DIV=4, REPEAT_CYCLES=40): cycle-segment table
// plus a held-key sequence whose expected strobe count depends on KEYPAD_REPEAT_EN.
module tb_keypad_scan_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] fila = 4'b0000;
  logic [3:0] col;
  logic [3:0] posicion;
  logic       opr;
  logic       key_held;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scan_fsm #(.SCAN_DIV(4), .REPEAT_CYCLES(40)) dut (
    .clk      (clk),
    .rst      (rst),
    .fila     (fila),
    .col      (col),
    .posicion (posicion),
    .opr      (opr),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] fila;
    int         ncyc;
    logic [3:0] col;
    logic [3:0] pos;
    logic       opr;
    logic       held;
  } seg_t;

  seg_t segs[31];

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s seg=%0d t=%0t actual=%b required=%b", name, idx, $time, act, exp);
    end
  endtask

  task automatic set_seg(input int i, input logic r, input logic [3:0] f, input int n,
                         input logic [3:0] c, input logic [3:0] p, input logic o, input logic h);
    segs[i].rst = r; segs[i].fila = f; segs[i].ncyc = n;
    segs[i].col = c; segs[i].pos = p; segs[i].opr = o; segs[i].held = h;
  endtask

  initial begin
    int opr_count;
    int offs[$];
    int waited;
    logic [3:0] exp_pos;

    // Reset, first tick advance
    set_seg( 0, 0, 4'b0000, 3, 4'b0001, 4'b0000, 0, 0);
    set_seg( 1, 1, 4'b0000, 3, 4'b0001, 4'b0000, 0, 0);
    set_seg( 2, 1, 4'b0000, 1, 4'b0010, 4'b0000, 0, 0);
    // Single press col1 row2
    set_seg( 3, 1, 4'b0100, 3, 4'b0010, 4'b0000, 0, 0);
    set_seg( 4, 1, 4'b0100, 4, 4'b0010, 4'b0110, 0, 0);
    set_seg( 5, 1, 4'b0100, 1, 4'b0010, 4'b0110, 1, 1);
    set_seg( 6, 1, 4'b0100, 4, 4'b0010, 4'b0110, 0, 1);
    set_seg( 7, 1, 4'b0000, 3, 4'b0010, 4'b0110, 0, 1);
    set_seg( 8, 1, 4'b0000, 1, 4'b0100, 4'b0110, 0, 0);
    // Multi-row at col2, then row change during HOLD
    set_seg( 9, 1, 4'b1010, 3, 4'b0100, 4'b0110, 0, 0);
    set_seg(10, 1, 4'b1010, 4, 4'b0100, 4'b1001, 0, 0);
    set_seg(11, 1, 4'b1010, 1, 4'b0100, 4'b1001, 1, 1);
    set_seg(12, 1, 4'b0010, 8, 4'b0100, 4'b1001, 0, 1);
    set_seg(13, 1, 4'b0000, 3, 4'b0100, 4'b1001, 0, 1);
    set_seg(14, 1, 4'b0000, 1, 4'b1000, 4'b1001, 0, 0);
    // Glitch at col3 for one dwell
    set_seg(15, 1, 4'b0001, 3, 4'b1000, 4'b1001, 0, 0);
    set_seg(16, 1, 4'b0001, 1, 4'b1000, 4'b1100, 0, 0);
    set_seg(17, 1, 4'b0000, 3, 4'b1000, 4'b1100, 0, 0);
    set_seg(18, 1, 4'b0000, 4, 4'b0001, 4'b1100, 0, 0);
    set_seg(19, 1, 4'b0000, 1, 4'b0010, 4'b1100, 0, 0);
    // Same key again after release
    set_seg(20, 1, 4'b0100, 3, 4'b0010, 4'b1100, 0, 0);
    set_seg(21, 1, 4'b0100, 4, 4'b0010, 4'b0110, 0, 0);
    set_seg(22, 1, 4'b0100, 1, 4'b0010, 4'b0110, 1, 1);
    set_seg(23, 1, 4'b0000, 3, 4'b0010, 4'b0110, 0, 1);
    set_seg(24, 1, 4'b0000, 1, 4'b0100, 4'b0110, 0, 0);
    // Press then reset while held
    set_seg(25, 1, 4'b1000, 3, 4'b0100, 4'b0110, 0, 0);
    set_seg(26, 1, 4'b1000, 4, 4'b0100, 4'b1011, 0, 0);
    set_seg(27, 1, 4'b1000, 1, 4'b0100, 4'b1011, 1, 1);
    set_seg(28, 0, 4'b1000, 1, 4'b0001, 4'b0000, 0, 0);
    set_seg(29, 1, 4'b0000, 3, 4'b0001, 4'b0000, 0, 0);
    set_seg(30, 1, 4'b0000, 1, 4'b0010, 4'b0000, 0, 0);

    for (int s = 0; s < 31; s++) begin
      for (int c = 0; c < segs[s].ncyc; c++) begin
        @(negedge clk);
        rst  = segs[s].rst;
        fila = segs[s].fila;
        @(posedge clk);
        #1;
        check("col",      s, col,               segs[s].col);
        check("posicion", s, posicion,          segs[s].pos);
        check("opr",      s, {3'b000, opr},      {3'b000, segs[s].opr});
        check("key_held", s, {3'b000, key_held}, {3'b000, segs[s].held});
      end
      $display("[TB] seg %0d rst=%b fila=%b col=%b pos=%b opr=%b held=%b",
               s, segs[s].rst, segs[s].fila, col, posicion, opr, key_held);
    end

    // Held key: count strobes over 100 cycles from HOLD entry
    @(negedge clk);
    fila = 4'b0100;
    exp_pos = 4'b0110;
    waited = 0;
    while (opr !== 1'b1 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_tests++;
    if (opr !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_entry_timeout actual=no_opr required=opr within 100 cycles");
    end
    opr_count = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (opr === 1'b1) begin
        opr_count++;
        offs.push_back(k);
        check("repeat_pos", k, posicion, exp_pos);
      end
    end
    check("hold_held", 99, {3'b000, key_held}, 4'b0001);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_count", 0, 4'(opr_count), 4'd3);
    if (offs.size() == 3) begin
      check("repeat_off1", 1, 4'(offs[1] / 10), 4'd4);
      check("repeat_off2", 2, 4'(offs[2] / 10), 4'd8);
      check("repeat_off1_lsd", 1, 4'(offs[1] % 10), 4'd0);
      check("repeat_off2_lsd", 2, 4'(offs[2] % 10), 4'd0);
    end
`else
    check("single_opr_count", 0, 4'(opr_count), 4'd1);
`endif
    $display("[TB] hold sequence: %0d opr pulses in 100 cycles", opr_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_fsm.md
# keypad_scan_fsm

Keypad column scanner and key-event generator for the 4x4 matrix keypad. It drives the column lines and reads the debounced row lines (one debouncer per row, upstream). It confirms a press over two scan dwells and encodes it as a 4-bit position. It issues a single-cycle write strobe that feeds the register bank write port (`addrW`/`RegWrite`), whose contents the VGA stage renders.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per column dwell (1 ms at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, 25000000: held-key repeat period in cycles; only used with `KEYPAD_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `fila`  in  4  debounced row inputs, active-high, bit i = row i.
- `col`  out  4  column drive, one-hot, active-high.
- `posicion`  out  4  key position `{col_idx[1:0], row_idx[1:0]}`, registered.
- `opr`  out  1  one-cycle key-event strobe; `posicion` is valid while high.
- `key_held`  out  1  high while a confirmed key remains pressed.

## Operation
- Dwell divider: free-running counter 0..SCAN_DIV-1. `tick` asserts when count = SCAN_DIV-1, then the counter wraps to 0.
- Row encode: `row_idx` is the lowest set bit of `fila`, so `fila[0]` has priority. For example, fila = 4'b0110 gives row_idx = 1.
- `col_idx` is the index of the set bit in `col`.
- States:
  - SCAN: `col` rotates 0001→0010→0100→1000→0001 on each `tick`.
    - At a tick with `fila` ≠ 0, `col` does not advance.
    - `posicion` captures `{col_idx,row_idx}` and the FSM goes to CONFIRM.
  - CONFIRM: `col` frozen. At the next tick:
    - If `fila` ≠ 0 and its lowest set bit equals the captured `row_idx`: go to HOLD and pulse `opr`.
    - Otherwise `col` advances and the FSM returns to SCAN. `posicion` keeps the stale capture, with no `opr`.
  - HOLD: `col` frozen, `key_held` = 1.
    - At a tick with `fila` = 0: go to SCAN and advance `col`.
    - Changes to other rows in the same column are ignored until release.
- Exactly one `opr` per confirmed press, plus repeats if configured. No event is ever generated in SCAN or CONFIRM.
- A second key pressed during HOLD generates nothing. After release, it is detected on its column's next dwell.

## Timing
- Reset values (`rst` = 0 sampled at a clock edge):
  - `col` = 4'b0001, `posicion` = 4'h0, `opr` = 0, `key_held` = 0.
  - State SCAN, divider = 0, repeat counter = 0.
- Reset has priority over every transition. Asserted mid-press, it drops `opr`/`key_held` on the next edge and restarts scanning at column 0.
- `fila` is sampled only on tick cycles. Row changes between ticks have no effect.
- `opr` rises on the clock edge after the confirming tick (registered) and is high for exactly one cycle. `key_held` rises on that same edge.
- Press-to-`opr` latency: 1 to 2 dwells after the press becomes visible on the driven column, plus 1 cycle. The worst case is a full 4-column rotation plus that.
- `posicion` changes only on SCAN→CONFIRM and is stable through `opr` and HOLD.
- `key_held` falls on the edge following the release tick.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HOLD, a repeat counter counts cycles from HOLD entry.
  - At each count of REPEAT_CYCLES it emits one extra one-cycle `opr` with unchanged `posicion`, then reloads to 0.
  - The counter clears on leaving HOLD.
- Undefined: the repeat counter is not synthesized, `REPEAT_CYCLES` is ignored, and there is exactly one `opr` per press.

## Structure
- Package `keypad_pkg`:
  - FSM state encoding (SCAN, CONFIRM, HOLD).
  - `COL_RESET` = 4'b0001.
  - Position field widths and offsets (col bits [3:2], row bits [1:0]).
- Sub-module `scan_tick_gen`: parameterized modulo-SCAN_DIV counter producing `tick`, with the same `clk`/`rst`.
- Everything else (row encoder, FSM, output registers, repeat counter) lives in the top of this block.

## Test plan
Bench uses SCAN_DIV = 4, REPEAT_CYCLES = 40.
- Reset: hold `rst` = 0 for 3 cycles → `col` = 0001, `posicion` = 0, `opr` = 0, `key_held` = 0; after release, `col` is 0010 on the first tick edge.
- Single press: assert `fila` = 0100 only while `col` = 0010 and hold it → `posicion` = 4'b0110, `opr` high for exactly 1 cycle, `key_held` = 1, `col` frozen at 0010.
- Glitch: `fila` = 0001 for a single dwell at `col` = 1000, then 0 → no `opr`, and scanning resumes at 0001.
- Multi-row: `fila` = 1010 at `col` = 0100 → `posicion` = 4'b1001, one `opr`; a later `fila` change to 0010 during HOLD → no further `opr`.
- Release: drop `fila` to 0 in HOLD → `key_held` falls within 4 cycles plus 1, `col` advances, and the same key pressed again → a new `opr`.
- With `KEYPAD_REPEAT_EN`: hold the key for 100 cycles after HOLD entry → 3 `opr` pulses total (entry, +40, +80), all with identical `posicion`.
